// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the data port (m0) and the
// instruction fetch port (m1). The winner is picked combinationally and owns
// the bus until the slave acks or the watchdog fires.
// Optional build macro ARB_ROUND_ROBIN_EN swaps fixed priority for round robin.
module mem_bus_arbiter #(
  parameter int unsigned p_timeout = 64,
  parameter bit          p_m0_prio = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic        m0_wr_en,
  input  logic [31:0] m0_wr_data,
  input  logic        m0_rd_en,
  output logic [31:0] m0_rd_data,
  output logic        m0_busy,
  output logic        m0_ack,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic        m1_wr_en,
  input  logic [31:0] m1_wr_data,
  input  logic        m1_rd_en,
  output logic [31:0] m1_rd_data,
  output logic        m1_busy,
  output logic        m1_ack,
  output logic [31:0] s_addr,
  output logic [3:0]  s_be,
  output logic        s_wr_en,
  output logic [31:0] s_wr_data,
  output logic        s_rd_en,
  input  logic [31:0] s_rd_data,
  input  logic        s_busy,
  input  logic        s_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  localparam int unsigned CNT_W = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (p_timeout > 0) ? CNT_W'(p_timeout - 1) : '0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OWN_M0 = 2'd1;
  localparam logic [1:0] ST_OWN_M1 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic m0_req, m1_req;
  logic pick_m1;
  logic sel_m0, sel_m1;
  logic own_state;
  logic wd_fire;
  logic done;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = m1 preferred on the next simultaneous request
  logic rr_q, rr_d;
`endif

  // Arbitration, watchdog and next-state logic
  always_comb begin
    m0_req = m0_rd_en | m0_wr_en;
    m1_req = m1_rd_en | m1_wr_en;

`ifdef ARB_ROUND_ROBIN_EN
    pick_m1 = m1_req & (~m0_req | rr_q);
`else
    pick_m1 = m1_req & (~m0_req | ~p_m0_prio);
`endif

    sel_m0 = 1'b0;
    sel_m1 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_m1 = pick_m1;
        sel_m0 = m0_req & ~pick_m1;
      end
      ST_OWN_M0: sel_m0 = 1'b1;
      ST_OWN_M1: sel_m1 = 1'b1;
      default: ;
    endcase

    own_state = (state_q == ST_OWN_M0) || (state_q == ST_OWN_M1);
    // A real ack in the same cycle wins over the watchdog
    wd_fire   = (p_timeout != 0) && own_state && !s_ack && (cnt_q == CNT_LAST);
    done      = (sel_m0 | sel_m1) & (s_ack | wd_fire);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sel_m0 && !s_ack) begin
          state_d = ST_OWN_M0;
        end else if (sel_m1 && !s_ack) begin
          state_d = ST_OWN_M1;
        end
      end
      ST_OWN_M0, ST_OWN_M1: begin
        if (done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (p_timeout != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef ARB_ROUND_ROBIN_EN
    rr_d = rr_q;
    if (done) begin
      rr_d = sel_m0;
    end
`endif
  end

  // Bus routing and requester responses; forced to zero while reset is held
  always_comb begin
    s_addr     = '0;
    s_be       = '0;
    s_wr_en    = 1'b0;
    s_wr_data  = '0;
    s_rd_en    = 1'b0;
    m0_rd_data = '0;
    m1_rd_data = '0;
    m0_busy    = 1'b0;
    m1_busy    = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    o_grant    = {sel_m1, sel_m0};
    o_timeout  = wd_fire;

    if (sel_m0 && !wd_fire) begin
      s_addr    = m0_addr;
      s_be      = m0_be;
      s_wr_en   = m0_wr_en;
      s_wr_data = m0_wr_data;
      s_rd_en   = m0_rd_en;
    end else if (sel_m1 && !wd_fire) begin
      s_addr    = m1_addr;
      s_be      = m1_be;
      s_wr_en   = m1_wr_en;
      s_wr_data = m1_wr_data;
      s_rd_en   = m1_rd_en;
    end

    if (sel_m0) begin
      m0_ack     = done;
      m0_rd_data = s_ack ? s_rd_data : '0;
      m0_busy    = s_busy & ~wd_fire;
      m1_busy    = own_state ? 1'b1 : m1_req;
    end else if (sel_m1) begin
      m1_ack     = done;
      m1_rd_data = s_ack ? s_rd_data : '0;
      m1_busy    = s_busy & ~wd_fire;
      m0_busy    = own_state ? 1'b1 : m0_req;
    end

    if (!i_rst_n) begin
      s_addr     = '0;
      s_be       = '0;
      s_wr_en    = 1'b0;
      s_wr_data  = '0;
      s_rd_en    = 1'b0;
      m0_rd_data = '0;
      m1_rd_data = '0;
      m0_busy    = 1'b0;
      m1_busy    = 1'b0;
      m0_ack     = 1'b0;
      m1_ack     = 1'b0;
      o_grant    = 2'b00;
      o_timeout  = 1'b0;
    end
  end

  // State, watchdog counter and round-robin pointer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected acks, an
// independent monitor pops and compares on every requester ack.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data;
  logic [3:0]  m0_be, m1_be;
  logic        m0_wr_en, m1_wr_en, m0_rd_en, m1_rd_en;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        m0_busy, m1_busy, m0_ack, m1_ack;
  logic [31:0] s_addr, s_wr_data, s_rd_data;
  logic [3:0]  s_be;
  logic        s_wr_en, s_rd_en, s_busy, s_ack;
  logic [1:0]  o_grant;
  logic        o_timeout;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mem_bus_arbiter #(.p_timeout(4), .p_m0_prio(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .m0_addr(m0_addr), .m0_be(m0_be), .m0_wr_en(m0_wr_en), .m0_wr_data(m0_wr_data),
    .m0_rd_en(m0_rd_en), .m0_rd_data(m0_rd_data), .m0_busy(m0_busy), .m0_ack(m0_ack),
    .m1_addr(m1_addr), .m1_be(m1_be), .m1_wr_en(m1_wr_en), .m1_wr_data(m1_wr_data),
    .m1_rd_en(m1_rd_en), .m1_rd_data(m1_rd_data), .m1_busy(m1_busy), .m1_ack(m1_ack),
    .s_addr(s_addr), .s_be(s_be), .s_wr_en(s_wr_en), .s_wr_data(s_wr_data),
    .s_rd_en(s_rd_en), .s_rd_data(s_rd_data), .s_busy(s_busy), .s_ack(s_ack),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic [31:0] data, input logic to);
    exp_t e;
    e.port = port;
    e.data = data;
    e.to   = to;
    sb.push_back(e);
  endtask

  // Monitor: every requester ack must match the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (m0_ack || m1_ack)) begin
      check("single_ack", 32'(m0_ack & m1_ack), 32'h0);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: got m0_ack=%b m1_ack=%b expected none", m0_ack, m1_ack);
      end else begin
        e = sb.pop_front();
        check("ack_port", 32'(m1_ack), 32'(e.port));
        check("ack_rd_data", m1_ack ? m1_rd_data : m0_rd_data, e.data);
        check("ack_timeout", 32'(o_timeout), 32'(e.to));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wr_data = '0; m1_wr_data = '0;
    m0_be = '0; m1_be = '0; m0_wr_en = 1'b0; m1_wr_en = 1'b0;
    m0_rd_en = 1'b1; m1_rd_en = 1'b0; m0_addr = 32'h44;
    s_rd_data = '0; s_busy = 1'b0; s_ack = 1'b0;

    // Reset state: outputs zero even with a request pending
    tick(); tick();
    @(negedge clk);
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_s_rd_en", 32'(s_rd_en), 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_m0_busy", 32'(m0_busy), 32'h0);
    tick();
    m0_rd_en = 1'b0; m0_addr = '0;
    rst_n = 1'b1;

    // Lone m1 read, ack three cycles after the request
    tick();
    m1_rd_en = 1'b1; m1_addr = 32'h100;
    push(1'b1, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    check("t1_s_rd_en", 32'(s_rd_en), 32'h1);
    check("t1_s_addr", s_addr, 32'h100);
    check("t1_grant0", 32'(o_grant), 32'h2);
    for (int i = 1; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("t1_grant_hold", 32'(o_grant), 32'h2);
      check("t1_no_early_ack", 32'(m1_ack), 32'h0);
    end
    tick();
    s_ack = 1'b1; s_rd_data = 32'hCAFEF00D;
    @(negedge clk);
    check("t1_ack", 32'(m1_ack), 32'h1);
    check("t1_grant_ack", 32'(o_grant), 32'h2);
    tick();
    s_ack = 1'b0; s_rd_data = '0; m1_rd_en = 1'b0;
    @(negedge clk);
    check("t1_idle_grant", 32'(o_grant), 32'h0);

    // Simultaneous m0 write and m1 read: m0 first
    tick();
    m0_wr_en = 1'b1; m0_addr = 32'h200; m0_wr_data = 32'hA5A5A5A5; m0_be = 4'b0011;
    m1_rd_en = 1'b1; m1_addr = 32'h300;
    push(1'b0, 32'h0, 1'b0);
    push(1'b1, 32'h12345678, 1'b0);
    @(negedge clk);
    check("t2_grant", 32'(o_grant), 32'h1);
    check("t2_s_wr_en", 32'(s_wr_en), 32'h1);
    check("t2_s_be", 32'(s_be), 32'h3);
    check("t2_s_wr_data", s_wr_data, 32'hA5A5A5A5);
    check("t2_s_addr", s_addr, 32'h200);
    check("t2_m1_busy0", 32'(m1_busy), 32'h1);
    tick();
    @(negedge clk);
    check("t2_m1_busy1", 32'(m1_busy), 32'h1);
    tick();
    s_ack = 1'b1;
    @(negedge clk);
    check("t2_m1_busy_ack", 32'(m1_busy), 32'h1);
    tick();
    s_ack = 1'b0; m0_wr_en = 1'b0; m0_be = '0; m0_wr_data = '0;
    @(negedge clk);
    check("t2_m1_grant", 32'(o_grant), 32'h2);
    check("t2_m1_busy_free", 32'(m1_busy), 32'h0);
    check("t2_m1_addr", s_addr, 32'h300);
    tick();
    s_ack = 1'b1; s_rd_data = 32'h12345678;
    tick();
    s_ack = 1'b0; s_rd_data = '0; m1_rd_en = 1'b0;

    // Same-cycle ack stays in IDLE; back-to-back m0 requests
    tick();
    m0_rd_en = 1'b1; m0_addr = 32'h400; s_ack = 1'b1; s_rd_data = 32'h11112222;
    push(1'b0, 32'h11112222, 1'b0);
    @(negedge clk);
    check("t3_s_addr0", s_addr, 32'h400);
    tick();
    m0_addr = 32'h404; s_rd_data = 32'h33334444;
    push(1'b0, 32'h33334444, 1'b0);
    @(negedge clk);
    check("t3_s_addr1", s_addr, 32'h404);
    check("t3_s_rd_en1", 32'(s_rd_en), 32'h1);
    tick();
    m0_rd_en = 1'b0; s_ack = 1'b0; s_rd_data = '0;
    m1_rd_en = 1'b1; m1_addr = 32'h500;
    push(1'b1, 32'h55, 1'b0);
    @(negedge clk);
    check("t3_idle_regrant", 32'(o_grant), 32'h2);
    check("t3_m1_addr", s_addr, 32'h500);
    tick();
    s_ack = 1'b1; s_rd_data = 32'h55;
    tick();
    s_ack = 1'b0; s_rd_data = '0; m1_rd_en = 1'b0;

    // Watchdog: slave never acks m0, m1 waits
    tick();
    m0_rd_en = 1'b1; m0_addr = 32'h600; m1_rd_en = 1'b1; m1_addr = 32'h700;
    s_rd_data = 32'hDEADBEEF;
    push(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("t4_grant", 32'(o_grant), 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("t4_no_timeout", 32'(o_timeout), 32'h0);
    end
    tick();
    @(negedge clk);
    check("t4_timeout", 32'(o_timeout), 32'h1);
    check("t4_ack", 32'(m0_ack), 32'h1);
    check("t4_rd_data", m0_rd_data, 32'h0);
    check("t4_s_rd_en", 32'(s_rd_en), 32'h0);
    check("t4_s_addr", s_addr, 32'h0);
    tick();
    m0_rd_en = 1'b0; m0_addr = '0;
    push(1'b1, 32'h77, 1'b0);
    @(negedge clk);
    check("t4_m1_grant", 32'(o_grant), 32'h2);
    check("t4_timeout_clr", 32'(o_timeout), 32'h0);
    tick();
    s_ack = 1'b1; s_rd_data = 32'h77;
    tick();
    s_ack = 1'b0; s_rd_data = '0; m1_rd_en = 1'b0;

`ifdef ARB_ROUND_ROBIN_EN
    // Round robin: both always requesting, every transfer acked at once
    m0_rd_en = 1'b1; m1_rd_en = 1'b1; m0_addr = 32'h900; m1_addr = 32'h904;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = 32'hA0 + 32'(i);
      tick();
      s_ack = 1'b1; s_rd_data = d;
      push(1'(i & 1), d, 1'b0);
      @(negedge clk);
      check("rr_grant", 32'(o_grant), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    tick();
    s_ack = 1'b0; s_rd_data = '0; m0_rd_en = 1'b0; m1_rd_en = 1'b0;
`endif

    // Reset during OWN_M1: outputs drop at once, no ack, IDLE afterwards
    tick();
    m1_rd_en = 1'b1; m1_addr = 32'h800;
    @(negedge clk);
    check("t6_grant_req", 32'(o_grant), 32'h2);
    tick();
    @(negedge clk);
    check("t6_grant_own", 32'(o_grant), 32'h2);
    @(posedge clk);
    #1;
    rst_n = 1'b0; s_ack = 1'b1; s_rd_data = 32'hBAD0BAD0;
    #1;
    check("t6_rst_grant", 32'(o_grant), 32'h0);
    check("t6_rst_s_addr", s_addr, 32'h0);
    check("t6_rst_s_rd_en", 32'(s_rd_en), 32'h0);
    check("t6_rst_m1_ack", 32'(m1_ack), 32'h0);
    check("t6_rst_m1_rd_data", m1_rd_data, 32'h0);
    tick();
    rst_n = 1'b1; s_ack = 1'b0; s_rd_data = '0; m1_rd_en = 1'b0; m1_addr = '0;
    @(negedge clk);
    check("t6_idle_grant", 32'(o_grant), 32'h0);
    check("t6_no_ack", 32'(m1_ack), 32'h0);

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory bus (addr/be/wr/rd/busy/ack) between two CPU requesters: data port (m0, driven by the memory stage) and instruction fetch port (m1).
- Sits between the core and the unified memory/interconnect.
- Arbitrates per transfer, holds the grant until the slave acknowledges, and routes busy/ack/read data back to the owner.
- A watchdog terminates transfers the slave never acknowledges.

Parameters:
- p_timeout, 64: cycles waiting for s_ack before forced termination; 0 disables the watchdog.
- p_m0_prio, 1: fixed-priority mode only. 1 = m0 (data) wins simultaneous requests; 0 = m1 wins.

Ports:
- i_clk  in  1  global clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- m0_addr / m1_addr  in  32  requester word address.
- m0_be / m1_be  in  4  requester byte enables.
- m0_wr_en / m1_wr_en  in  1  requester write request.
- m0_wr_data / m1_wr_data  in  32  requester write data.
- m0_rd_en / m1_rd_en  in  1  requester read request.
- m0_rd_data / m1_rd_data  out  32  read data returned to requester.
- m0_busy / m1_busy  out  1  requester must hold its request.
- m0_ack / m1_ack  out  1  requester transfer complete, 1-cycle pulse.
- s_addr  out  32  slave address.
- s_be  out  4  slave byte enables.
- s_wr_en  out  1  slave write request.
- s_wr_data  out  32  slave write data.
- s_rd_en  out  1  slave read request.
- s_rd_data  in  32  slave read data.
- s_busy  in  1  slave busy.
- s_ack  in  1  slave acknowledge.
- o_grant  out  2  one-hot current owner: [0]=m0, [1]=m1.
- o_timeout  out  1  1-cycle pulse when the watchdog fires.

Behaviour:
- Request: mX_req = mX_rd_en | mX_wr_en. A requester holds its request and payload stable until it sees mX_ack.
- FSM states: IDLE, OWN_M0, OWN_M1. Reset state is IDLE; timeout counter = 0; round-robin pointer selects m0.
- Outputs in reset: s_* = 0, m*_ack = 0, m*_busy = 0, o_grant = 0, o_timeout = 0, m*_rd_data = 0.
- IDLE:
  - Winner is chosen combinationally; its payload drives s_* in the same cycle (zero added latency).
  - Loser sees busy = 1.
  - If the winner has s_ack in the same cycle: ack is forwarded and the FSM stays IDLE.
  - Otherwise the FSM moves to OWN_<winner>.
  - No request: s_* = 0.
- OWN_X:
  - s_* = mX payload; mX_busy = s_busy; other requester busy = 1; o_grant = X.
  - On s_ack: mX_ack = 1 for that cycle, then return to IDLE. The next arbitration happens the following cycle; there is no back-to-back grant in the ack cycle.
  - If mX drops its request without an ack (protocol violation): the grant is still held until ack or timeout.
- Read data:
  - s_rd_data goes to the owner's rd_data, combinationally, in the ack cycle; the other requester's rd_data = 0.
  - Non-owner ack is always 0.
  - A slave ack arriving in IDLE with no request is ignored.
- Watchdog (p_timeout > 0):
  - Counter clears on entering OWN_X and increments each OWN cycle without s_ack.
  - When the counter reaches p_timeout-1 without ack: owner gets ack = 1 with rd_data = 32'h0, o_timeout pulses, s_* = 0 that cycle, FSM returns to IDLE.
  - A real ack in the same cycle takes precedence; o_timeout = 0 in that case.
  - Counter width = $clog2(p_timeout+1).
- Fixed priority (default): simultaneous requests are resolved by p_m0_prio.
- Reset asserted mid-transfer: immediate return to the reset state. The pending transfer is dropped with no ack.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Simultaneous requests in IDLE go to the requester not granted most recently.
  - Pointer updates on every completed transfer (ack or timeout).
  - p_m0_prio is ignored.
  - A single requester is always granted regardless of the pointer.
- Undefined: fixed priority per p_m0_prio; no pointer register.

Test Plan:
- Lone m1 read, addr 0x100, s_ack 3 cycles later with s_rd_data 0xCAFEF00D → s_rd_en=1 and s_addr=0x100 in the request cycle; m1_ack=1 with m1_rd_data=0xCAFEF00D exactly in the ack cycle; o_grant=2'b10 throughout.
- m0 write 0xA5A5A5A5 with be=4'b0011 and m1 read in the same cycle, fixed p_m0_prio=1 → m0 served first; m1_busy=1 until the cycle after m0_ack; m1 then granted.
- Same-cycle ack: m0 read with s_ack in the request cycle → m0_ack that cycle; FSM stays IDLE; a new m0 request next cycle is forwarded with no gap.
- Watchdog with p_timeout=4: slave never acks → m0_ack and o_timeout pulse on the 4th OWN cycle with m0_rd_data=0; a pending m1 is granted the next cycle.
- Round robin (ARB_ROUND_ROBIN_EN): both requesters continuously active for 4 transfers → grant order m0, m1, m0, m1.
- i_rst_n low for 1 cycle during OWN_M1 → all outputs 0 immediately; no m1_ack; FSM IDLE after release.
